// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit of the RISC-V datapath:
//   - funct3 encodings for the load/store access sizes
//   - lsu_state_t and its state constants (IDLE, REQ, DONE)
//   - accessError(): decides whether a request can go to the bus at all
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    // funct3 encodings; bit 2 selects zero extension, bits 1:0 the size
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU control states
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE = 2'd0;
    localparam lsu_state_t REQ  = 2'd1;
    localparam lsu_state_t DONE = 2'd2;

    // An access is refused when its funct3 is not a load/store size this
    // core supports (unsigned variants exist only for loads) or when the
    // address is not naturally aligned for the access size.
    function automatic logic accessError(input logic       isStore,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addrLo);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (isStore && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addrLo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addrLo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
// Data-memory request/ready bus between the LSU and the memory.
//   bus_req   LSU -> mem  request active
//   bus_we    LSU -> mem  1 = write
//   bus_addr  LSU -> mem  word-aligned address
//   bus_be    LSU -> mem  byte enables
//   bus_wdata LSU -> mem  lane-replicated store data
//   bus_ready mem -> LSU  request accepted/completed this cycle
//   bus_rdata mem -> LSU  read data, valid with bus_ready
// master = LSU side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational lane select and sign/zero extension of load data.
//   i_rdata   32  raw word from the bus
//   i_addrLo   2  low address bits of the access
//   i_funct3   3  access size/sign
//   o_data    32  extended load result
// ---------------------------------------------------------------------------
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addrLo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half out of the word, then extend
    // according to the size and the unsigned bit of funct3.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addrLo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit after the ALU: one data-memory access per load/store over
// a request/ready bus, with stall, done/err reporting and a wait timeout.
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_req_valid   load/store present (held while o_stall=1)
//   i_mem_write   1 = store, 0 = load
//   i_funct3      access size/sign
//   i_alu_result  effective address
//   i_store_data  rs2 value
//   o_stall       core must hold (combinational)
//   o_done        one-cycle completion pulse
//   o_err         misaligned / illegal / timeout, valid with o_done
//   o_load_data   extended load result, held until the next o_done
//   bus           memory bus (master side)
// TIMEOUT_CYCLES: wait cycles allowed in REQ before abort, 0 = no timeout.
// ---------------------------------------------------------------------------
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_valid,
    input  logic                 i_mem_write,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_alu_result,
    input  logic [31:0]          i_store_data,
    output logic                 o_stall,
    output logic                 o_done,
    output logic                 o_err,
    output logic [31:0]          o_load_data,
    lsu_mem_stage_if.master      bus
);

    localparam logic [7:0] TIMEOUT8 = TIMEOUT_CYCLES[7:0];

    lsu_state_t  r_state;
    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [3:0]  r_busBe;
    logic [31:0] r_busWdata;
    logic [1:0]  r_addrLo;
    logic [2:0]  r_funct3;
    logic [7:0]  r_waitCnt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_loadData;

    logic        w_accErr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_alignData;
    logic [7:0]  w_cntNext;

    assign w_accErr  = accessError(i_mem_write, i_funct3, i_alu_result[1:0]);
    assign w_cntNext = r_waitCnt + 8'd1;

    // Byte enables and lane-replicated write data for the incoming request.
    // The enables are produced for loads too so the memory sees the lanes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_alu_result[1:0];
                w_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_store_data;
            end
        endcase
    end

    // Lane select/extension works on the latched access, not the live
    // core inputs, so the result matches what was put on the bus.
    lsu_load_align u_loadAlign (
        .i_rdata  (bus.bus_rdata),
        .i_addrLo (r_addrLo),
        .i_funct3 (r_funct3),
        .o_data   (w_alignData)
    );

    // Access sequencer. Refused requests skip the bus and report straight
    // through DONE. In REQ a ready beats a timeout that lands in the same
    // cycle; the wait counter only ever advances on cycles without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= 32'h0;
            r_busBe    <= 4'h0;
            r_busWdata <= 32'h0;
            r_addrLo   <= 2'b00;
            r_funct3   <= 3'b000;
            r_waitCnt  <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_loadData <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_req_valid) begin
                        if (w_accErr) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                            r_loadData <= 32'h0;
                        end else begin
                            r_state    <= REQ;
                            r_busReq   <= 1'b1;
                            r_busWe    <= i_mem_write;
                            r_busAddr  <= {i_alu_result[31:2], 2'b00};
                            r_busBe    <= w_be;
                            r_busWdata <= w_wdata;
                            r_addrLo   <= i_alu_result[1:0];
                            r_funct3   <= i_funct3;
                            r_waitCnt  <= 8'h00;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ready) begin
                        r_state  <= DONE;
                        r_busReq <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b0;
                        if (!r_busWe) begin
                            r_loadData <= w_alignData;
                        end
                    end else if ((TIMEOUT8 != 8'h00) && (w_cntNext == TIMEOUT8)) begin
                        r_state    <= DONE;
                        r_busReq   <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_loadData <= 32'h0;
                    end else begin
                        r_waitCnt <= w_cntNext;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall = ((r_state == IDLE) && i_req_valid) || (r_state == REQ);

    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_load_data   = r_loadData;
    assign bus.bus_req   = r_busReq;
    assign bus.bus_we    = r_busWe;
    assign bus.bus_addr  = r_busAddr;
    assign bus.bus_be    = r_busBe;
    assign bus.bus_wdata = r_busWdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
// Self-checking bench for lsu_mem_stage with TIMEOUT_CYCLES=4. A memory
// responder answers after a chosen number of wait cycles; expected lanes,
// load values, latency and error outcome come from a model of the access
// rules written with plain arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_load_data;

    int          checkCount;
    int          failCount;
    logic [31:0] lastLoad;

    lsu_mem_stage_if busIf ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_load_data  (o_load_data),
        .bus          (busIf)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference rule: which requests never reach the bus
    function automatic bit modelRefused(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
        bit legal;
        bit aligned;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
        case (f3)
            3'd1, 3'd5: aligned = (addr % 2) == 0;
            3'd2:       aligned = (addr % 4) == 0;
            default:    aligned = 1'b1;
        endcase
        return !(legal && aligned);
    endfunction

    // Reference rule: value a load returns from a given bus word
    function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                              input logic [31:0] addr,
                                              input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // One instruction: present it, play memory with `waits` wait cycles,
    // then check bus contents, latency, stall length and outcome.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input int waits, input logic [31:0] rdata);
        int          cyc;
        int          reqCycles;
        int          stallCnt;
        bit          seen;
        bit          refused;
        bit          timedOut;
        int          expLat;
        int          expReq;
        logic [31:0] expBe;
        logic [31:0] expWdata;
        logic [31:0] expLoad;
        int          sz;

        @(negedge clk);
        checkOutput("done_low_before", 32'(o_done), 32'd0);
        checkOutput("load_held", o_load_data, lastLoad);
        i_req_valid  = 1'b1;
        i_mem_write  = we;
        i_funct3     = f3;
        i_alu_result = addr;
        i_store_data = sdata;
        busIf.bus_ready = 1'b0;
        busIf.bus_rdata = $urandom();
        #1;
        stallCnt = o_stall ? 1 : 0;

        refused  = modelRefused(we, f3, addr);
        timedOut = !refused && (waits >= TO);
        sz = int'(f3 % 4);
        if (sz == 0) begin
            expBe    = 32'd1 << (addr % 4);
            expWdata = (sdata & 32'hFF) * 32'h01010101;
        end else if (sz == 1) begin
            expBe    = ((addr % 4) >= 2) ? 32'hC : 32'h3;
            expWdata = (sdata & 32'hFFFF) * 32'h00010001;
        end else begin
            expBe    = 32'hF;
            expWdata = sdata;
        end
        if (refused)       begin expLat = 1;         expReq = 0;      end
        else if (timedOut) begin expLat = TO + 1;    expReq = TO;     end
        else               begin expLat = waits + 2; expReq = waits + 1; end

        cyc       = 0;
        reqCycles = 0;
        seen      = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_done) begin
                seen = 1'b1;
                busIf.bus_ready = 1'($urandom_range(0, 1));
            end else begin
                if (o_stall) stallCnt++;
                if (busIf.bus_req) begin
                    reqCycles++;
                    if (reqCycles == 1) begin
                        checkOutput("bus_addr", busIf.bus_addr, addr & 32'hFFFFFFFC);
                        checkOutput("bus_be", 32'(busIf.bus_be), expBe);
                        checkOutput("bus_we", 32'(busIf.bus_we), 32'(we));
                        if (we) checkOutput("bus_wdata", busIf.bus_wdata, expWdata);
                    end
                    busIf.bus_ready = (reqCycles == waits + 1);
                    busIf.bus_rdata = (reqCycles == waits + 1) ? rdata : $urandom();
                end else begin
                    busIf.bus_ready = 1'($urandom_range(0, 1));
                end
            end
        end

        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("latency", 32'(cyc), 32'(expLat));
        checkOutput("req_cycles", 32'(reqCycles), 32'(expReq));
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expLat));
        checkOutput("stall_in_done", 32'(o_stall), 32'd0);
        checkOutput("err", 32'(o_err), 32'(refused || timedOut));
        if (refused || timedOut) begin
            expLoad  = 32'h0;
            lastLoad = expLoad;
            checkOutput("load_zero_on_err", o_load_data, expLoad);
        end else if (!we) begin
            expLoad  = modelLoad(f3, addr, rdata);
            lastLoad = expLoad;
            checkOutput("load_data", o_load_data, expLoad);
        end
    endtask

    initial begin
        checkCount      = 0;
        failCount       = 0;
        lastLoad        = 32'h0;
        rst_n           = 1'b0;
        i_req_valid     = 1'b0;
        i_mem_write     = 1'b0;
        i_funct3        = 3'd0;
        i_alu_result    = 32'h0;
        i_store_data    = 32'h0;
        busIf.bus_ready = 1'b0;
        busIf.bus_rdata = 32'h0;

        #23;
        checkOutput("rst_bus_req", 32'(busIf.bus_req), 32'd0);
        checkOutput("rst_bus_addr", busIf.bus_addr, 32'd0);
        checkOutput("rst_bus_be", 32'(busIf.bus_be), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_load", o_load_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the access rules
        applyStimulus(1'b1, 3'd0, 32'h00001003, 32'h000000A5, 0, 32'h0);
        applyStimulus(1'b0, 3'd0, 32'h00002001, 32'h0, 0, 32'h00008000);
        applyStimulus(1'b0, 3'd4, 32'h00002001, 32'h0, 1, 32'h00008000);
        applyStimulus(1'b0, 3'd5, 32'h00002002, 32'h0, 0, 32'hBEEF0000);
        applyStimulus(1'b0, 3'd2, 32'h00003002, 32'h0, 0, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h00003000, 32'h0, 3, 32'h12345678);
        applyStimulus(1'b0, 3'd2, 32'h00003000, 32'h0, 50, 32'h0);
        applyStimulus(1'b0, 3'd1, 32'h00003006, 32'h0, 4, 32'hCAFE0000);
        applyStimulus(1'b1, 3'd4, 32'h00004000, 32'h11223344, 0, 32'h0);
        applyStimulus(1'b1, 3'd1, 32'h00004002, 32'h0000BEEF, 2, 32'h0);

        // Randomized traffic, occasionally with idle gaps
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                i_req_valid = 1'b0;
            end
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom(), $urandom(), $urandom_range(0, 6), $urandom());
        end

        // Reset while a request waits on the bus
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_mem_write  = 1'b0;
        i_funct3     = 3'd2;
        i_alu_result = 32'h00005000;
        busIf.bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_req_bus_req", 32'(busIf.bus_req), 32'd1);
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        #1;
        checkOutput("arst_bus_req", 32'(busIf.bus_req), 32'd0);
        checkOutput("arst_bus_addr", busIf.bus_addr, 32'd0);
        checkOutput("arst_bus_we", 32'(busIf.bus_we), 32'd0);
        checkOutput("arst_done", 32'(o_done), 32'd0);
        checkOutput("arst_err", 32'(o_err), 32'd0);
        checkOutput("arst_load", o_load_data, 32'd0);
        checkOutput("arst_stall", 32'(o_stall), 32'd0);
        lastLoad = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_idle_stall", 32'(o_stall), 32'd0);
        checkOutput("post_rst_idle_req", 32'(busIf.bus_req), 32'd0);
        applyStimulus(1'b0, 3'd0, 32'h00002001, 32'h0, 0, 32'h00008000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
